conv_mem_responder: RTL and testbench
=====================================

Name: conv_mem_responder

Overview:
- Responder side of the CONV memory/image interface.
- Holds the 64x64 image ROM, the layer-0 RAM (4096 words) and the layer-1 RAM (1024 words).
- Serves image and layer reads with zero-latency asynchronous reads, and accepts synchronous writes.
- Sequences a host image load, issues `ready` to the CONV engine, tracks `busy`, and provides a host readback port once the run completes.

Parameters:
- DATA_W, 20, pixel/feature word width
- IMG_DIM, 64, image side length; image depth = IMG_DIM*IMG_DIM
- L1_DEPTH, 1024, layer-1 words (IMG_DIM/2 squared)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- ld_valid  in  1  host image word valid
- ld_data  in  20  host image word, raster order
- ld_ready  out  1  responder accepts image word
- ready  out  1  image loaded, CONV may start
- busy  in  1  CONV engine busy
- iaddr  in  12  image address {row,col}
- idata  out  20  image word at iaddr, combinational
- cwr  in  1  layer write enable
- caddr_wr  in  12  layer write address
- cdata_wr  in  20  layer write data
- crd  in  1  layer read enable
- caddr_rd  in  12  layer read address
- csel  in  3  3'b001 = L0, 3'b011 = L1, others = no access
- cdata_rd  out  20  layer read data, combinational
- rb_req  in  1  host readback request (S_DONE only)
- rb_sel  in  1  0 = L0, 1 = L1
- rb_addr  in  12  readback address
- rb_valid  out  1  readback data valid
- rb_data  out  20  readback data
- done  out  1  run complete
- proto_err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- FSM states are S_EMPTY, S_LOAD, S_READY, S_RUN, S_DONE.
- Reset values:
  - state = S_EMPTY, load counter = 0.
  - ready, done, rb_valid, proto_err = 0; rb_data = 0; ld_ready = 1.
  - Memory contents are not reset.
- S_EMPTY: the first ld_valid&&ld_ready handshake writes ld_data to image[0], sets counter to 1, and moves to S_LOAD.
- S_LOAD: each handshake writes image[counter] and increments the counter.
  - The handshake that writes address 4095 moves to S_READY and forces ld_ready = 0 from the next cycle.
  - ld_valid low stalls loading with no timeout.
- ld_ready = 1 in S_EMPTY, S_LOAD and S_DONE; 0 in S_READY and S_RUN.
- S_READY: ready = 1 (registered).
  - The first cycle busy = 1 is sampled moves to S_RUN and ready drops in the same edge.
- S_RUN: layer accesses are honoured.
  - busy sampled 0 moves to S_DONE, and done = 1 from the next cycle.
  - done stays 1 until a new load starts.
- S_DONE: a handshake on ld_valid restarts loading (image[0] written, counter = 1, S_LOAD) and clears done.
- Image read: idata = image[iaddr] combinationally, in every state. Consumers sample one cycle after presenting the registered address.
- Layer write, on posedge when cwr = 1:
  - csel 001: L0[caddr_wr] <= cdata_wr.
  - csel 011: L1[caddr_wr[9:0]] <= cdata_wr.
  - Any other csel: no write.
- Layer read: when crd = 1, cdata_rd = L0[caddr_rd] or L1[caddr_rd[9:0]] per csel; otherwise cdata_rd = 0.
- Same-address write and read in one cycle: read returns the old value (write-after-read ordering).
- Layer accesses outside S_RUN are still performed. Only the protocol checker flags them.
- Readback: rb_req in S_DONE returns rb_data = selected memory at rb_addr (L1 uses rb_addr[9:0]) with rb_valid = 1 exactly one cycle later.
  - rb_req outside S_DONE is ignored (rb_valid stays 0).
- Reset mid-load or mid-run: returns to S_EMPTY immediately and asynchronously. ready and done drop. A fresh 4096-word load is required.

Optional Feature:
- Macro CONV_MEM_PROTO_CHECK_EN.
- Defined: proto_err is set (sticky until reset) on any of:
  - cwr && crd in the same cycle;
  - cwr or crd with csel not 001/011;
  - L1 access with address bits [11:10] != 0;
  - cwr or crd while state != S_RUN;
  - iaddr change while state is S_EMPTY/S_LOAD.
- Undefined: proto_err is tied 0 and no checker logic is generated.

Decomposition:
- Package conv_pkg holds:
  - CSEL_L0 = 3'b001, CSEL_L1 = 3'b011;
  - DATA_W, IMG_DIM, ADDR_W = 12;
  - resp_state_t enum (S_EMPTY..S_DONE).
- Sub-module conv_mem_bank (params DEPTH, DATA_W): async-read, sync-write RAM with optional registered second read port for readback. It is instantiated three times (image, L0, L1).

Test Plan:
- Load ramp ld_data = addr for 4096 words, with ld_valid dropped for 5 cycles at word 100. Required: ready rises the cycle after the 4096th handshake; iaddr = 12'h041 gives idata = 20'h00041.
- In S_RUN, cwr = 1, csel = 001, caddr_wr = 12'h7FF, cdata_wr = 20'h12345; the next cycle crd = 1, caddr_rd = 12'h7FF. Required: cdata_rd = 20'h12345. Also drive a same-cycle write and read to 12'h7FF with 20'hABCDE: required cdata_rd = 20'h12345 (old value).
- L1 write csel = 011, caddr_wr = 12'h3FF, data 20'h0F0F0, then busy falls. Required: done = 1; rb_req, rb_sel = 1, rb_addr = 12'h3FF gives rb_valid = 1 with 20'h0F0F0 one cycle later.
- busy raised 3 cycles after ready. Required: ready clears on the busy sample; ld_ready = 0 throughout S_RUN; ld_valid pulses are ignored.
- Assert reset at load word 2000, then reload. Required: ready only after a full 4096 new words; done = 0.
- With CONV_MEM_PROTO_CHECK_EN, drive cwr = 1, csel = 010 in S_RUN. Required: proto_err = 1 next cycle, held until reset, with no memory modified. Without the macro, proto_err = 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and types for the CONV memory responder.
package conv_pkg;
    localparam int DATA_W    = 20;
    localparam int IMG_DIM   = 64;
    localparam int ADDR_W    = 12;
    localparam int IMG_DEPTH = IMG_DIM * IMG_DIM;
    localparam int L1_DEPTH  = (IMG_DIM / 2) * (IMG_DIM / 2);

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic [2:0] {
        S_EMPTY,
        S_LOAD,
        S_READY,
        S_RUN,
        S_DONE
    } resp_state_t;
endpackage

// File: rtl/conv_mem_bank.sv
// Async-read / sync-write RAM with an optional registered readback port.
// Contents are never reset; only the readback register is.
module conv_mem_bank #(
    parameter int DEPTH  = 4096,
    parameter int DATA_W = 20,
    parameter bit RB_EN  = 1'b0,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              rb_en,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Synchronous write; a same-cycle read of the same word sees the old value.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

    generate
        if (RB_EN) begin : g_rb
            logic [DATA_W-1:0] rb_q;
            // Readback word captured one cycle after the request.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)        rb_q <= '0;
                else if (rb_en) rb_q <= mem_q[rb_addr];
            end
            assign rb_data = rb_q;
        end else begin : g_no_rb
            logic unused_rb;
            assign unused_rb = ^{rst, rb_en, rb_addr};
            assign rb_data   = '0;
        end
    endgenerate
endmodule

// File: rtl/conv_mem_responder.sv
// Responder side of the CONV memory/image interface: image ROM loaded by
// the host, L0/L1 layer RAMs, run sequencing and host readback.
// Optional protocol checker: define CONV_MEM_PROTO_CHECK_EN.
module conv_mem_responder
    import conv_pkg::*;
#(
    parameter int DATA_W   = conv_pkg::DATA_W,
    parameter int IMG_DIM  = conv_pkg::IMG_DIM,
    parameter int L1_DEPTH = conv_pkg::L1_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ready,
    input  logic              busy,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] idata,
    input  logic              cwr,
    input  logic [ADDR_W-1:0] caddr_wr,
    input  logic [DATA_W-1:0] cdata_wr,
    input  logic              crd,
    input  logic [ADDR_W-1:0] caddr_rd,
    input  logic [2:0]        csel,
    output logic [DATA_W-1:0] cdata_rd,
    input  logic              rb_req,
    input  logic              rb_sel,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic              rb_valid,
    output logic [DATA_W-1:0] rb_data,
    output logic              done,
    output logic              proto_err
);
    localparam int L1_AW = $clog2(L1_DEPTH);

    resp_state_t       state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ld_ready_q, ready_q, done_q, rb_valid_q, rb_sel_q;

    logic              hs, rb_go;
    logic [ADDR_W-1:0] img_waddr;
    logic [DATA_W-1:0] l0_rd, l1_rd, l0_rb, l1_rb;

    // ld_ready is only high in states that accept image words.
    assign hs        = ld_valid && ld_ready_q;
    assign img_waddr = (state_q == S_LOAD) ? cnt_q : '0;
    assign rb_go     = rb_req && (state_q == S_DONE);

    // Run sequencer with registered handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            cnt_q      <= '0;
            ld_ready_q <= 1'b1;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            rb_valid_q <= 1'b0;
            rb_sel_q   <= 1'b0;
        end else begin
            rb_valid_q <= rb_go;
            if (rb_go) rb_sel_q <= rb_sel;
            case (state_q)
                S_EMPTY, S_DONE: if (hs) begin
                    state_q <= S_LOAD;
                    cnt_q   <= ADDR_W'(1);
                    done_q  <= 1'b0;
                end
                S_LOAD: if (hs) begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == '1) begin
                        state_q    <= S_READY;
                        ld_ready_q <= 1'b0;
                        ready_q    <= 1'b1;
                    end
                end
                S_READY: if (busy) begin
                    state_q <= S_RUN;
                    ready_q <= 1'b0;
                end
                S_RUN: if (!busy) begin
                    state_q    <= S_DONE;
                    done_q     <= 1'b1;
                    ld_ready_q <= 1'b1;
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    conv_mem_bank #(.DEPTH(IMG_DIM*IMG_DIM), .DATA_W(DATA_W), .RB_EN(1'b0)) u_img (
        .clk(clk), .rst(reset),
        .we(hs), .waddr(img_waddr), .wdata(ld_data),
        .raddr(iaddr), .rdata(idata),
        .rb_en(1'b0), .rb_addr('0), .rb_data()
    );

    conv_mem_bank #(.DEPTH(IMG_DIM*IMG_DIM), .DATA_W(DATA_W), .RB_EN(1'b1)) u_l0 (
        .clk(clk), .rst(reset),
        .we(cwr && (csel == CSEL_L0)), .waddr(caddr_wr), .wdata(cdata_wr),
        .raddr(caddr_rd), .rdata(l0_rd),
        .rb_en(rb_go && !rb_sel), .rb_addr(rb_addr), .rb_data(l0_rb)
    );

    conv_mem_bank #(.DEPTH(L1_DEPTH), .DATA_W(DATA_W), .RB_EN(1'b1)) u_l1 (
        .clk(clk), .rst(reset),
        .we(cwr && (csel == CSEL_L1)), .waddr(caddr_wr[L1_AW-1:0]), .wdata(cdata_wr),
        .raddr(caddr_rd[L1_AW-1:0]), .rdata(l1_rd),
        .rb_en(rb_go && rb_sel), .rb_addr(rb_addr[L1_AW-1:0]), .rb_data(l1_rb)
    );

    // Layer read port: zero unless an enabled read targets a valid bank.
    always_comb begin
        cdata_rd = '0;
        if (crd && csel == CSEL_L0) cdata_rd = l0_rd;
        if (crd && csel == CSEL_L1) cdata_rd = l1_rd;
    end

    assign ld_ready = ld_ready_q;
    assign ready    = ready_q;
    assign done     = done_q;
    assign rb_valid = rb_valid_q;
    assign rb_data  = rb_sel_q ? l1_rb : l0_rb;

`ifdef CONV_MEM_PROTO_CHECK_EN
    logic [ADDR_W-1:0] iaddr_q;
    logic              proto_q, viol;

    // Any illegal access pattern seen this cycle.
    always_comb begin
        viol = 1'b0;
        if (cwr && crd) viol = 1'b1;
        if ((cwr || crd) && !(csel == CSEL_L0 || csel == CSEL_L1)) viol = 1'b1;
        if (cwr && csel == CSEL_L1 && caddr_wr[ADDR_W-1:L1_AW] != '0) viol = 1'b1;
        if (crd && csel == CSEL_L1 && caddr_rd[ADDR_W-1:L1_AW] != '0) viol = 1'b1;
        if ((cwr || crd) && state_q != S_RUN) viol = 1'b1;
        if ((state_q == S_EMPTY || state_q == S_LOAD) && iaddr != iaddr_q) viol = 1'b1;
    end

    // Sticky error flag; iaddr history detects address churn during load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iaddr_q <= '0;
            proto_q <= 1'b0;
        end else begin
            iaddr_q <= iaddr;
            if (viol) proto_q <= 1'b1;
        end
    end

    assign proto_err = proto_q;
`else
    assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_conv_mem_responder.sv
// Directed + randomized bench for conv_mem_responder with a memory model.
module tb_conv_mem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [19:0] ld_data;
    logic        ld_ready, ready, busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr, crd;
    logic [11:0] caddr_wr, caddr_rd;
    logic [19:0] cdata_wr, cdata_rd;
    logic [2:0]  csel;
    logic        rb_req, rb_sel, rb_valid, done, proto_err;
    logic [11:0] rb_addr;
    logic [19:0] rb_data;

    int errors = 0;
    int checks = 0;

    logic [19:0] img_m [4096];
    logic [19:0] l0_m  [4096];
    logic [19:0] l1_m  [1024];
    logic        exp_proto;

    logic        op_sel [16];
    logic [11:0] op_addr [16];

    always #5 clk = ~clk;

    conv_mem_responder dut (
        .clk(clk), .reset(reset),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .csel(csel), .cdata_rd(cdata_rd),
        .rb_req(rb_req), .rb_sel(rb_sel), .rb_addr(rb_addr),
        .rb_valid(rb_valid), .rb_data(rb_data),
        .done(done), .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n words into image[start..]; ramp data or random data.
    task automatic do_load(input int start, input int n, input bit rnd, input int pause_at);
        for (int i = 0; i < n; i++) begin
            if (i == pause_at) begin
                ld_valid = 1'b0;
                for (int p = 0; p < 5; p++) begin
                    tick();
                    chk("ready_low_during_stall", ready, 0);
                end
            end
            ld_valid = 1'b1;
            ld_data  = rnd ? 20'($urandom) : 20'(start + i);
            img_m[start + i] = ld_data;
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic idata_rand(input int n);
        for (int k = 0; k < n; k++) begin
            iaddr = 12'($urandom_range(0, 4095));
            #1;
            chk("idata_rand", idata, img_m[iaddr]);
        end
    endtask

    initial begin
        exp_proto = 1'b0;
        reset = 1'b1; ld_valid = 0; ld_data = 0; busy = 0; iaddr = 0;
        cwr = 0; crd = 0; caddr_wr = 0; caddr_rd = 0; cdata_wr = 0; csel = 0;
        rb_req = 0; rb_sel = 0; rb_addr = 0;
        tick(); tick();
        chk("rst_ready", ready, 0);
        chk("rst_done", done, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_rb_valid", rb_valid, 0);
        chk("rst_rb_data", rb_data, 0);
        chk("rst_proto", proto_err, 0);
        reset = 1'b0;
        tick();

        // Ramp load with a stall at word 100.
        do_load(0, 4095, 1'b0, 100);
        chk("ready_before_last", ready, 0);
        chk("ld_ready_before_last", ld_ready, 1);
        do_load(4095, 1, 1'b0, -1);
        chk("ready_after_last", ready, 1);
        chk("ld_ready_after_last", ld_ready, 0);
        iaddr = 12'h041; #1;
        chk("idata_041", idata, 20'h00041);
        idata_rand(4);

        // busy rises 3 cycles after ready.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ready_hold", ready, 1);
        end
        busy = 1'b1;
        tick();
        chk("ready_drop_on_busy", ready, 0);
        chk("ld_ready_run", ld_ready, 0);
        ld_valid = 1'b1; ld_data = 20'hFFFFF;
        tick();
        ld_valid = 1'b0;
        chk("ld_ready_run2", ld_ready, 0);
        chk("done_run", done, 0);
        iaddr = 12'h000; #1;
        chk("img0_untouched", idata, img_m[0]);

        // L0 write then read, then same-cycle write/read.
        cwr = 1; csel = 3'b001; caddr_wr = 12'h7FF; cdata_wr = 20'h12345;
        tick();
        l0_m[12'h7FF] = 20'h12345;
        cwr = 0; crd = 1; caddr_rd = 12'h7FF; #1;
        chk("l0_rd_7ff", cdata_rd, 20'h12345);
        cwr = 1; cdata_wr = 20'hABCDE; #1;
        chk("l0_war_old", cdata_rd, 20'h12345);
`ifdef CONV_MEM_PROTO_CHECK_EN
        exp_proto = 1'b1;
`endif
        tick();
        l0_m[12'h7FF] = 20'hABCDE;
        cwr = 0; #1;
        chk("l0_war_new", cdata_rd, 20'hABCDE);
        crd = 0; #1;
        chk("crd_off_zero", cdata_rd, 0);

        // Random layer writes, read back against the model.
        for (int k = 0; k < 16; k++) begin
            op_sel[k]  = 1'($urandom);
            op_addr[k] = op_sel[k] ? 12'($urandom_range(0, 1023)) : 12'($urandom_range(0, 4095));
            cwr = 1; csel = op_sel[k] ? 3'b011 : 3'b001;
            caddr_wr = op_addr[k]; cdata_wr = 20'($urandom);
            if (op_sel[k]) l1_m[op_addr[k][9:0]] = cdata_wr;
            else           l0_m[op_addr[k]]      = cdata_wr;
            tick();
        end
        cwr = 0;
        for (int k = 0; k < 16; k++) begin
            crd = 1; csel = op_sel[k] ? 3'b011 : 3'b001; caddr_rd = op_addr[k]; #1;
            chk("layer_rand", cdata_rd, op_sel[k] ? l1_m[op_addr[k][9:0]] : l0_m[op_addr[k]]);
        end
        crd = 0;

        // L1 write at top address, then end the run.
        cwr = 1; csel = 3'b011; caddr_wr = 12'h3FF; cdata_wr = 20'h0F0F0;
        tick();
        l1_m[10'h3FF] = 20'h0F0F0;
        cwr = 0;
        chk("done_before_busy_fall", done, 0);
        busy = 0;
        tick();
        chk("done_set", done, 1);
        chk("ld_ready_done", ld_ready, 1);
        rb_req = 1; rb_sel = 1; rb_addr = 12'h3FF;
        tick();
        chk("rb_valid_l1", rb_valid, 1);
        chk("rb_data_l1", rb_data, 20'h0F0F0);
        rb_sel = 0; rb_addr = 12'h7FF;
        tick();
        rb_req = 0;
        chk("rb_valid_l0", rb_valid, 1);
        chk("rb_data_l0", rb_data, l0_m[12'h7FF]);
        tick();
        chk("rb_valid_drop", rb_valid, 0);
        chk("proto_run1", proto_err, exp_proto);

        // Restart from S_DONE with random data, reset at word 2000.
        do_load(0, 2000, 1'b1, -1);
        chk("done_cleared_on_load", done, 0);
        reset = 1; #1;
        chk("midrst_ready", ready, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ld_ready", ld_ready, 1);
        chk("midrst_proto", proto_err, 0);
        reset = 0; exp_proto = 0;
        tick();
        do_load(0, 4095, 1'b1, -1);
        chk("reload_ready_early", ready, 0);
        do_load(4095, 1, 1'b1, -1);
        chk("reload_ready", ready, 1);
        chk("reload_done", done, 0);
        idata_rand(6);

        // rb_req outside S_DONE, then an illegal csel write in S_RUN.
        busy = 1;
        tick();
        rb_req = 1; rb_sel = 0; rb_addr = 12'h7FF;
        tick();
        rb_req = 0;
        chk("rb_ignored_run", rb_valid, 0);
        cwr = 1; csel = 3'b010; caddr_wr = 12'h7FF; cdata_wr = 20'h55555;
        tick();
        cwr = 0;
`ifdef CONV_MEM_PROTO_CHECK_EN
        exp_proto = 1'b1;
`endif
        chk("proto_bad_csel", proto_err, exp_proto);
        crd = 1; csel = 3'b001; caddr_rd = 12'h7FF; #1;
        chk("l0_unmodified", cdata_rd, l0_m[12'h7FF]);
        csel = 3'b011; caddr_rd = 12'h3FF; #1;
        chk("l1_unmodified", cdata_rd, l1_m[10'h3FF]);
        crd = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("proto_sticky", proto_err, exp_proto);
        end
        busy = 0;
        reset = 1; #1;
        chk("proto_rst", proto_err, 0);
        reset = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
